// File: rtl/systolic_result_drain.sv
// Drains NUM_PE accumulated PE results onto a valid/ready stream after a settle period.
// Define DRAIN_SNAPSHOT_EN to capture all words into a local bank on entry to streaming.
module systolic_result_drain #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned NUM_PE        = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_PE*WIDTH-1:0] in_c_flat,
  output logic                    pe_done_flag,
  output logic [WIDTH-1:0]        m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    busy,
  output logic                    clear_req
);

  localparam int unsigned IdxW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NUM_PE - 1);
  localparam logic [CntW-1:0] SettleInit = CntW'(SETTLE_CYCLES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFlush  = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StStream = 3'd3;
  localparam logic [2:0] StClear  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              load;
  logic              xfer;
  logic [WIDTH-1:0]  word_sel;
  logic [NUM_PE*WIDTH-1:0] src_flat;

  logic              pe_done_flag_q, pe_done_flag_d;
  logic [WIDTH-1:0]  m_tdata_q, m_tdata_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              m_tlast_q, m_tlast_d;
  logic              busy_q, busy_d;
  logic              clear_req_q, clear_req_d;

  assign xfer = m_tvalid_q & m_tready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFlush;
      end
      StFlush: begin
        state_d = StSettle;
        cnt_d   = SettleInit;
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StStream;
          idx_d   = '0;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StStream: begin
        if (xfer) begin
          if (idx_q == LastIdx) begin
            state_d = StClear;
          end else begin
            idx_d = idx_q + 1'b1;
            load  = 1'b1;
          end
        end
      end
      StClear: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef DRAIN_SNAPSHOT_EN
  logic [NUM_PE*WIDTH-1:0] bank_q, bank_d;

  // Bank loads on the same edge that enters streaming, so the first word reads through.
  always_comb begin
    bank_d = bank_q;
    if (state_q == StSettle && state_d == StStream) bank_d = in_c_flat;
  end

  always_ff @(posedge clk) begin
    if (reset) bank_q <= '0;
    else       bank_q <= bank_d;
  end

  assign src_flat = bank_d;
`else
  assign src_flat = in_c_flat;
`endif

  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (idx_d == IdxW'(i)) word_sel = src_flat[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    pe_done_flag_d = (state_d == StFlush);
    busy_d         = (state_d != StIdle);
    clear_req_d    = (state_d == StClear);
    m_tvalid_d     = (state_d == StStream);
    m_tlast_d      = m_tvalid_d && (idx_d == LastIdx);
    m_tdata_d      = load ? word_sel : m_tdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      idx_q          <= '0;
      pe_done_flag_q <= 1'b0;
      m_tdata_q      <= '0;
      m_tvalid_q     <= 1'b0;
      m_tlast_q      <= 1'b0;
      busy_q         <= 1'b0;
      clear_req_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pe_done_flag_q <= pe_done_flag_d;
      m_tdata_q      <= m_tdata_d;
      m_tvalid_q     <= m_tvalid_d;
      m_tlast_q      <= m_tlast_d;
      busy_q         <= busy_d;
      clear_req_q    <= clear_req_d;
    end
  end

  assign pe_done_flag = pe_done_flag_q;
  assign m_tdata      = m_tdata_q;
  assign m_tvalid     = m_tvalid_q;
  assign m_tlast      = m_tlast_q;
  assign busy         = busy_q;
  assign clear_req    = clear_req_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: directed tables, corner sequences and
// randomized traffic checked against a cycle-timeline reference model.
module tb_systolic_result_drain;

  localparam int W = 16;
  localparam int N = 4;
  localparam int S = 8;
`ifdef DRAIN_SNAPSHOT_EN
  localparam bit Snap = 1'b1;
`else
  localparam bit Snap = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset, start, m_tready;
  logic [N*W-1:0] in_c_flat;
  logic           pe_done_flag, m_tvalid, m_tlast, busy, clear_req;
  logic [W-1:0]   m_tdata;

  logic           start1, m_tready1;
  logic [W-1:0]   in1;
  logic           pe_done1, m_tvalid1, m_tlast1, busy1, clear1;
  logic [W-1:0]   m_tdata1;

  systolic_result_drain #(.WIDTH(W), .NUM_PE(N), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_c_flat(in_c_flat),
    .pe_done_flag(pe_done_flag), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .clear_req(clear_req)
  );

  systolic_result_drain #(.WIDTH(W), .NUM_PE(1), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_c_flat(in1),
    .pe_done_flag(pe_done1), .m_tdata(m_tdata1), .m_tvalid(m_tvalid1),
    .m_tready(m_tready1), .m_tlast(m_tlast1), .busy(busy1), .clear_req(clear1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a drain is a timeline anchored at the accepted start cycle t0.
  bit         mon_en = 1'b0;
  bit         m_act = 1'b0;
  int         m_t0, m_nb, m_tl;
  logic [W-1:0] m_cur;
  logic [W-1:0] m_bank [N];
  bit         pe_e, v_e, clr_e, busy_e;

  always @(negedge clk) begin
    if (mon_en) begin
      pe_e   = m_act && (cyc == m_t0 + 1);
      busy_e = m_act && (cyc >= m_t0 + 1);
      v_e    = m_act && (cyc >= m_t0 + 2 + S) && (m_nb < N);
      clr_e  = m_act && (m_nb == N) && (cyc == m_tl + 1);
      chk("mdl_pe_done", {31'd0, pe_done_flag}, {31'd0, pe_e});
      chk("mdl_busy", {31'd0, busy}, {31'd0, busy_e});
      chk("mdl_valid", {31'd0, m_tvalid}, {31'd0, v_e});
      chk("mdl_clear", {31'd0, clear_req}, {31'd0, clr_e});
      if (v_e) begin
        chk("mdl_data", {16'd0, m_tdata}, {16'd0, m_cur});
        chk("mdl_last", {31'd0, m_tlast}, {31'd0, (m_nb == N - 1)});
      end
      if (m_act && cyc == m_t0 + 1 + S) begin
        for (int k = 0; k < N; k++) m_bank[k] = in_c_flat[k*W +: W];
        m_cur = m_bank[0];
      end
      if (v_e && m_tready) begin
        if (m_nb < N - 1) m_cur = Snap ? m_bank[m_nb+1] : in_c_flat[(m_nb+1)*W +: W];
        m_nb++;
        if (m_nb == N) m_tl = cyc;
      end
      if (clr_e || reset) m_act = 1'b0;
      else if (!m_act && start) begin
        m_act = 1'b1;
        m_t0  = cyc;
        m_nb  = 0;
        m_tl  = -1;
      end
    end
  end

  typedef struct {
    bit           pe;
    bit           v;
    logic [W-1:0] d;
    bit           last;
    bit           bsy;
    bit           clr;
  } vec_t;

  localparam logic [N*W-1:0] Nominal = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};

  vec_t tbl [16];
  logic [W-1:0] words [N];
  int n_pe, n_beat, n_clr;

  initial begin
    words[0] = 16'h3C00; words[1] = 16'h4000; words[2] = 16'h4200; words[3] = 16'h4400;
    for (int c = 0; c < 16; c++) begin
      tbl[c].pe   = (c == 1);
      tbl[c].bsy  = (c >= 1 && c <= 14);
      tbl[c].v    = (c >= 10 && c <= 13);
      tbl[c].d    = tbl[c].v ? words[c-10] : 16'h0;
      tbl[c].last = (c == 13);
      tbl[c].clr  = (c == 14);
    end

    reset = 1'b1; start = 1'b0; m_tready = 1'b1; in_c_flat = Nominal;
    start1 = 1'b0; m_tready1 = 1'b1; in1 = 16'h4500;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pe_done", {31'd0, pe_done_flag}, 32'd0);
    chk("rst_tdata", {16'd0, m_tdata}, 32'd0);
    chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_tlast", {31'd0, m_tlast}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_clear", {31'd0, clear_req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Nominal burst, table-driven
    for (int r = 0; r < 16; r++) begin
      start = (r == 0);
      @(negedge clk);
      chk("nom_pe_done", {31'd0, pe_done_flag}, {31'd0, tbl[r].pe});
      chk("nom_valid", {31'd0, m_tvalid}, {31'd0, tbl[r].v});
      if (tbl[r].v) chk("nom_data", {16'd0, m_tdata}, {16'd0, tbl[r].d});
      chk("nom_last", {31'd0, m_tlast}, {31'd0, tbl[r].last});
      chk("nom_busy", {31'd0, busy}, {31'd0, tbl[r].bsy});
      chk("nom_clear", {31'd0, clear_req}, {31'd0, tbl[r].clr});
      @(posedge clk); #1;
    end
    start = 1'b0;

    // Backpressure on the first beat
    for (int r = 0; r < 20; r++) begin
      start = (r == 0);
      m_tready = !(r >= 10 && r <= 12);
      @(negedge clk);
      if (r == 12) begin
        chk("bp_hold_valid", {31'd0, m_tvalid}, 32'd1);
        chk("bp_hold_data", {16'd0, m_tdata}, 32'h3C00);
      end
      if (r == 16) chk("bp_last", {31'd0, m_tlast}, 32'd1);
      if (r == 17) chk("bp_clear", {31'd0, clear_req}, 32'd1);
      @(posedge clk); #1;
    end
    start = 1'b0; m_tready = 1'b1;

    // Start while busy is ignored
    n_pe = 0; n_beat = 0; n_clr = 0;
    for (int r = 0; r < 20; r++) begin
      start = (r == 0 || r == 5 || r == 12);
      @(negedge clk);
      n_pe   += int'(pe_done_flag);
      n_beat += int'(m_tvalid && m_tready);
      n_clr  += int'(clear_req);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_start_pe", n_pe, 32'd1);
    chk("busy_start_beats", n_beat, 32'd4);
    chk("busy_start_clear", n_clr, 32'd1);

    // Reset mid-stream, then a fresh burst
    n_clr = 0;
    for (int r = 0; r < 36; r++) begin
      start = (r == 0 || r == 20);
      reset = (r == 11);
      @(negedge clk);
      if (r == 12) begin
        chk("rstm_valid", {31'd0, m_tvalid}, 32'd0);
        chk("rstm_busy", {31'd0, busy}, 32'd0);
      end
      if (r >= 12 && r < 20) n_clr += int'(clear_req);
      if (r == 30) chk("rstm_restart_data", {16'd0, m_tdata}, 32'h3C00);
      if (r == 34) chk("rstm_restart_clear", {31'd0, clear_req}, 32'd1);
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b0;
    chk("rstm_no_clear", n_clr, 32'd0);

    // Input changes during streaming
    for (int r = 0; r < 16; r++) begin
      start = (r == 0);
      in_c_flat = (r >= 11) ? {N*W{1'b1}} : Nominal;
      @(negedge clk);
      if (r == 12) chk("snap_beat2", {16'd0, m_tdata}, Snap ? 32'h4200 : 32'hFFFF);
      if (r == 13) chk("snap_beat3", {16'd0, m_tdata}, Snap ? 32'h4400 : 32'hFFFF);
      @(posedge clk); #1;
    end
    start = 1'b0; in_c_flat = Nominal;

    // Single PE instance
    for (int r = 0; r < 6; r++) begin
      start1 = (r == 0);
      @(negedge clk);
      chk("pe1_valid", {31'd0, m_tvalid1}, {31'd0, (r == 3)});
      chk("pe1_last", {31'd0, m_tlast1}, {31'd0, (r == 3)});
      if (r == 3) chk("pe1_data", {16'd0, m_tdata1}, 32'h4500);
      chk("pe1_clear", {31'd0, clear1}, {31'd0, (r == 4)});
      chk("pe1_busy", {31'd0, busy1}, {31'd0, (r >= 1 && r <= 4)});
      @(posedge clk); #1;
    end
    start1 = 1'b0;

    // Randomized traffic against the model
    for (int r = 0; r < 600; r++) begin
      start = ($urandom % 8) == 0;
      m_tready = ($urandom % 4) != 0;
      reset = ($urandom % 150) == 0;
      for (int k = 0; k < N; k++) in_c_flat[k*W +: W] = W'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b0; m_tready = 1'b1;
    repeat (30) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
